fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 23 ++
 rtl/fetch_perf_ctr.sv | 47 ++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: instruction/address widths, the PC step,
// the fetch FSM state encoding and a PC alignment helper.
// Optional feature macro used by importers: FETCH_PERF_EN (performance counters).
package fetch_stage_pkg;

    localparam int unsigned INSN_WIDTH      = 32;
    localparam int unsigned INSN_ADDR_WIDTH = 32;
    localparam logic [INSN_ADDR_WIDTH-1:0] PC_STEP = 32'd4;

    typedef logic [INSN_WIDTH-1:0]      InsnPath;
    typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;

    typedef enum logic [0:0] {
        StBoot,
        StRun
    } fetch_state_e;

    // Word-align an address by clearing its byte offset bits.
    function automatic InsnAddrPath align_pc(input InsnAddrPath pc);
        return {pc[INSN_ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters (instantiated only when FETCH_PERF_EN is defined).
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset, clears both counters
//   run_i          fetch FSM is in RUN
//   valid_i        insn_valid from the fetch stage
//   stall_i        decode stall
//   fetch_cnt_o    number of handoffs (valid and not stalled), wraps at 2^32
//   bubble_cnt_o   RUN cycles with no valid instruction or with a stall, wraps at 2^32
module fetch_perf_ctr (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    input  logic        valid_i,
    input  logic        stall_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (valid_i && !stall_i) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (run_i && (!valid_i || stall_i)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-cycle-latency instruction memory.
// The memory latches imem_addr at each rising edge and returns the data in the
// following cycle, so req_pc (what was latched) is the address of imem_insn.
// Optional feature: define FETCH_PERF_EN to add fetch_cnt / bubble_cnt outputs.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   imem_addr            next address for instruction memory
//   imem_insn            instruction memory read data
//   stall                decode cannot accept this cycle
//   redirect/redirect_pc taken branch/jump and its target
//   insn_out/pc_out      instruction and its address to decode
//   insn_valid           insn_out/pc_out are meaningful
//   misalign_err         sticky: a redirect target had non-zero bits [1:0]
//   fetch_cnt/bubble_cnt (FETCH_PERF_EN only) handoff and bubble counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter InsnAddrPath RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output InsnAddrPath imem_addr,
    input  InsnPath     imem_insn,
    input  logic        stall,
    input  logic        redirect,
    input  InsnAddrPath redirect_pc,
    output InsnPath     insn_out,
    output InsnAddrPath pc_out,
    output logic        insn_valid,
    output logic        misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    fetch_state_e state_q, state_d;
    InsnAddrPath  req_pc_q, req_pc_d;
    logic         misalign_q, misalign_d;

    always_comb begin
        state_d    = state_q;
        misalign_d = misalign_q;
        imem_addr  = RESET_PC;
        insn_valid = 1'b0;
        if (!rst) begin
            case (state_q)
                StBoot: begin
                    state_d = StRun;
                end
                StRun: begin
                    if (redirect) begin
                        // Current instruction is wrong-path; fetch the target instead.
                        imem_addr = align_pc(redirect_pc);
                        if (redirect_pc[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
                    end else if (stall) begin
                        // Re-read the same word so insn_out holds steady.
                        imem_addr  = req_pc_q;
                        insn_valid = 1'b1;
                    end else begin
                        imem_addr  = req_pc_q + PC_STEP;
                        insn_valid = 1'b1;
                    end
                end
                default: begin
                    state_d = StBoot;
                end
            endcase
        end
    end

    // Memory latches imem_addr at the edge, so that becomes the next req_pc.
    assign req_pc_d = imem_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StBoot;
            req_pc_q   <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out       = req_pc_q;
    assign insn_out     = imem_insn;
    assign misalign_err = misalign_q;

`ifdef FETCH_PERF_EN
    fetch_perf_ctr u_perf_ctr (
        .clk_i        (clk),
        .rst_i        (rst),
        .run_i        (state_q == StRun),
        .valid_i      (insn_valid),
        .stall_i      (stall),
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_insn;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] insn_out;
    logic [31:0] pc_out;
    logic        insn_valid;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .RESET_PC (RstPc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_insn    (imem_insn),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .insn_out     (insn_out),
        .pc_out       (pc_out),
        .insn_valid   (insn_valid),
        .misalign_err (misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt    (fetch_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: latches the address at the edge, returns data a cycle later.
    function automatic logic [31:0] insn_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    logic [31:0] mem_addr_q;
    always @(posedge clk) mem_addr_q <= imem_addr;
    assign imem_insn = insn_of(mem_addr_q);

    // Reference model: the PC decode currently sees and what it sees next.
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_mis;
    int unsigned m_fetch;
    int unsigned m_bubble;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One non-reset cycle: drive, check mid-cycle, advance model past the edge.
    task automatic cycle(input logic s, input logic r, input logic [31:0] rp);
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] n_pc;
        bit          n_mis;
        rst = 1'b0; stall = s; redirect = r; redirect_pc = rp;
        #4;
        n_mis = m_mis;
        if (m_boot) begin
            e_valid = 1'b0; e_addr = RstPc; n_pc = RstPc;
        end else if (r) begin
            e_valid = 1'b0; e_addr = rp & 32'hFFFF_FFFC; n_pc = e_addr;
            if (rp % 4 != 0) n_mis = 1'b1;
        end else if (s) begin
            e_valid = 1'b1; e_addr = m_pc; n_pc = m_pc;
        end else begin
            e_valid = 1'b1; e_addr = m_pc + 32'd4; n_pc = e_addr;
        end
        chk("insn_valid", {31'd0, insn_valid}, {31'd0, e_valid});
        chk("imem_addr", imem_addr, e_addr);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        if (e_valid) begin
            chk("pc_out", pc_out, m_pc);
            chk("insn_out", insn_out, insn_of(m_pc));
        end
`ifdef FETCH_PERF_EN
        chk("fetch_cnt", fetch_cnt, m_fetch);
        chk("bubble_cnt", bubble_cnt, m_bubble);
`endif
        if (!m_boot) begin
            if (e_valid && !s) m_fetch++;
            if (!e_valid || s) m_bubble++;
        end
        @(posedge clk); #1;
        m_boot = 1'b0; m_pc = n_pc; m_mis = n_mis;
    endtask

    // One reset cycle; stall/redirect are driven with junk to show they are ignored.
    task automatic rst_cycle();
        rst = 1'b1; stall = 1'($urandom); redirect = 1'($urandom); redirect_pc = $urandom;
        #4;
        chk("rst_valid", {31'd0, insn_valid}, 32'd0);
        @(posedge clk); #1;
        m_boot = 1'b1; m_mis = 1'b0; m_fetch = 0; m_bubble = 0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        m_boot = 1'b1; m_pc = RstPc; m_mis = 1'b0; m_fetch = 0; m_bubble = 0;
        @(posedge clk); #1;
        rst_cycle();

        // Reset release: BOOT then 0x100, 0x104, 0x108.
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        chk("pc_at_108", pc_out, 32'h108);
        // Stall three cycles at 0x108, then release to 0x10C.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("pc_after_stall", pc_out, 32'h10C);
        // Redirect to 0x200 while stalled.
        cycle(1, 1, 32'h200);
        chk("pc_redirect_200", pc_out, 32'h200);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        // Misaligned redirect: address aligned, sticky error.
        cycle(0, 1, 32'h302);
        chk("misalign_set", {31'd0, misalign_err}, 32'd1);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        // Redirect to the top word, then wrap to zero.
        cycle(0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0);
        chk("wrap_zero", pc_out, 32'h0);
        cycle(0, 0, 0);
        // Reset in the middle of a stall discards state and clears the error.
        cycle(1, 0, 0);
        rst_cycle();
        chk("misalign_clr", {31'd0, misalign_err}, 32'd0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            int unsigned d;
            logic [31:0] t;
            d = $urandom_range(0, 99);
            t = $urandom;
            if (d < 2) begin
                rst_cycle();
            end else begin
                if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
                cycle(1'($urandom_range(0, 3) == 0), 1'(d < 12), t);
            end
        end

`ifdef FETCH_PERF_EN
        // 10 handoffs with 2 stall cycles after reset.
        rst_cycle();
        cycle(0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'(i == 3 || i == 7), 0, 0);
        end
        chk("perf_fetch10", fetch_cnt, 32'd10);
        chk("perf_bubble2", bubble_cnt, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
